// File: rtl/slave_credit_shell.sv
// Slave-side credit shell: buffers NoC requests, issues them to a shared slave,
// tags each issue with its source ID and returns in-order replies that carry credits.

module scs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] after_pop, level_nxt;
  logic [W-1:0]  head_nxt;
  logic          pop_ok, push_ok;

  // Full is judged after the same-cycle pop; head is kept registered so the
  // consumer sees a stable value that only changes on a pop or a fill-from-empty.
  always_comb begin
    pop_ok    = pop && (level != '0);
    after_pop = level - LW'(pop_ok);
    push_ok   = push && (after_pop != LW'(DEPTH));
    drop      = push && !push_ok;
    level_nxt = after_pop + LW'(push_ok);
    rd_nxt    = rd_ptr + PW'(pop_ok);
    if (after_pop == '0) head_nxt = push_ok ? din : '0;
    else                 head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

module slave_credit_shell #(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [ID_WIDTH-1:0]    req_id,
  output logic                   slv_valid,
  output logic [DATA_WIDTH-1:0]  slv_data,
  input  logic                   slv_ready,
  input  logic                   slv_rsp_valid,
  input  logic [RESP_WIDTH-1:0]  slv_rsp_data,
  output logic                   rsp_valid,
  output logic [RESP_WIDTH-1:0]  rsp_data,
  output logic [ID_WIDTH-1:0]    rsp_id,
  input  logic                   rsp_ready,
  output logic [$clog2(DEPTH):0] req_level,
  output logic                   overflow,
  output logic                   orphan
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a cycle where valid && ready; valid and
  // its payload never change while valid is high and ready is low.
  logic [ID_WIDTH+DATA_WIDTH-1:0] req_head;
  logic [ID_WIDTH+RESP_WIDTH-1:0] rsp_head;
  logic [ID_WIDTH-1:0]            slv_id, tag_head;
  logic [LW-1:0]                  tag_level, rsp_level;
  logic                           req_drop, tag_drop, rsp_drop;
  logic                           slv_hs, tag_valid, rsp_push;

  assign {slv_id, slv_data} = req_head;
  assign {rsp_id, rsp_data} = rsp_head;
  assign slv_valid = (req_level != '0);
  assign rsp_valid = (rsp_level != '0);
  assign tag_valid = (tag_level != '0);
  assign slv_hs    = slv_valid && slv_ready;
  // A reply consumes the tag that was outstanding before this edge; no bypass.
  assign rsp_push  = slv_rsp_valid && tag_valid;

  scs_fifo #(.W(ID_WIDTH + DATA_WIDTH), .DEPTH(DEPTH)) u_req_fifo (
    .clk(clk), .rst(rst), .push(req_valid), .din({req_id, req_data}),
    .pop(slv_ready), .head(req_head), .level(req_level), .drop(req_drop)
  );

  scs_fifo #(.W(ID_WIDTH), .DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk), .rst(rst), .push(slv_hs), .din(slv_id),
    .pop(slv_rsp_valid), .head(tag_head), .level(tag_level), .drop(tag_drop)
  );

  scs_fifo #(.W(ID_WIDTH + RESP_WIDTH), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .din({tag_head, slv_rsp_data}),
    .pop(rsp_ready), .head(rsp_head), .level(rsp_level), .drop(rsp_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      orphan   <= 1'b0;
    end else begin
      if (req_drop || tag_drop || rsp_drop) overflow <= 1'b1;
      if (slv_rsp_valid && !tag_valid)      orphan   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_slave_credit_shell.sv
// Scenario bench for slave_credit_shell: expected issues and replies are queued
// as stimulus is driven and popped by monitors when the DUT produces them.

module tb_slave_credit_shell;
  localparam int DW    = 32;
  localparam int RW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic [IW-1:0] req_id = '0;
  logic          slv_valid;
  logic [DW-1:0] slv_data;
  logic          slv_ready = 1'b0;
  logic          slv_rsp_valid = 1'b0;
  logic [RW-1:0] slv_rsp_data = '0;
  logic          rsp_valid;
  logic [RW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          rsp_ready = 1'b0;
  logic [3:0]    req_level;
  logic          overflow;
  logic          orphan;

  int errors = 0;
  int checks = 0;

  logic [IW+DW-1:0] exp_q[$];
  logic [IW+RW-1:0] exp_rsp_q[$];
  logic [IW-1:0]    tag_q[$];
  logic [IW+DW-1:0] mon_req;
  logic [IW+RW-1:0] mon_rsp;
  logic [IW-1:0]    ids[4] = '{4'd1, 4'd2, 4'd1, 4'd4};

  always #5 clk = ~clk;

  slave_credit_shell #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_id(req_id),
    .slv_valid(slv_valid), .slv_data(slv_data), .slv_ready(slv_ready),
    .slv_rsp_valid(slv_rsp_valid), .slv_rsp_data(slv_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .req_level(req_level), .overflow(overflow), .orphan(orphan)
  );

  // Scoreboard monitors: sample on the falling edge, ahead of the transferring edge.
  always @(negedge clk) begin
    if (!rst && slv_valid && slv_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got slv_data=%h, required no issue", slv_data);
      end else begin
        mon_req = exp_q.pop_front();
        tag_q.push_back(mon_req[IW+DW-1:DW]);
        if (slv_data !== mon_req[DW-1:0]) begin
          errors++;
          $display("FAIL issue_order: got slv_data=%h, required %h", slv_data, mon_req[DW-1:0]);
        end
      end
    end
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++;
        $display("FAIL reply_unexpected: got id=%h data=%h, required no reply", rsp_id, rsp_data);
      end else begin
        mon_rsp = exp_rsp_q.pop_front();
        if ({rsp_id, rsp_data} !== mon_rsp) begin
          errors++;
          $display("FAIL reply_order: got id=%h data=%h, required id=%h data=%h",
                   rsp_id, rsp_data, mon_rsp[IW+RW-1:RW], mon_rsp[RW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; slv_ready = 1'b0; slv_rsp_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    exp_q.delete(); exp_rsp_q.delete(); tag_q.delete();
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [IW-1:0] id, input logic [DW-1:0] data, input bit expect_issue);
    req_valid = 1'b1; req_id = id; req_data = data;
    if (expect_issue) exp_q.push_back({id, data});
  endtask

  // Drives one reply for the next tick; the model tag queue decides its ID.
  task automatic send_rsp(input logic [RW-1:0] data);
    slv_rsp_valid = 1'b1; slv_rsp_data = data;
    if (tag_q.size() != 0) exp_rsp_q.push_back({tag_q.pop_front(), data});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    req_valid = 1'b0; slv_ready = 1'b1; rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || tag_q.size() != 0 || exp_rsp_q.size() != 0) && n < 200) begin
      slv_rsp_valid = 1'b0;
      if (tag_q.size() != 0) send_rsp($urandom);
      tick();
      n++;
    end
    slv_rsp_valid = 1'b0;
    tick(); tick();
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: got %0d cycles with work left, required under 200", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({slv_valid, rsp_valid, slv_data, rsp_data, rsp_id, req_level, overflow, orphan} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sv=%b rv=%b sd=%h rd=%h id=%h lvl=%0d ov=%b or=%b, required all 0",
               slv_valid, rsp_valid, slv_data, rsp_data, rsp_id, req_level, overflow, orphan);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    slv_ready = 1'b1; rsp_ready = 1'b1;
    drive_req(4'd3, 32'hA5, 1'b1);
    tick();
    req_valid = 1'b0;
    checks++;
    if (slv_valid !== 1'b1 || slv_data !== 32'hA5) begin
      errors++; $display("FAIL single_issue: got v=%b d=%h, required v=1 d=000000a5", slv_valid, slv_data);
    end
    tick();
    checks++;
    if (slv_valid !== 1'b0) begin
      errors++; $display("FAIL single_issue_clear: got v=%b, required 0", slv_valid);
    end
    tick();
    send_rsp(32'h5A);
    tick();
    slv_rsp_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h5A || rsp_id !== 4'd3) begin
      errors++;
      $display("FAIL single_reply: got v=%b d=%h id=%h, required v=1 d=0000005a id=3", rsp_valid, rsp_data, rsp_id);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_reply_clear: got v=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(IW'(i), $urandom, 1'b1);
      tick();
    end
    checks++;
    if (req_level !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL stall_full: got lvl=%0d ov=%b, required lvl=8 ov=0", req_level, overflow);
    end
    drive_req(4'd9, 32'hDEADBEEF, 1'b0);
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_level !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL stall_overflow: got lvl=%0d ov=%b, required lvl=8 ov=1", req_level, overflow);
    end
    drain("stall");
  endtask

  task automatic test_full_pop();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(IW'(i), $urandom, 1'b1);
      tick();
    end
    slv_ready = 1'b1;
    drive_req(4'd8, $urandom, 1'b1);
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_level !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pop: got lvl=%0d ov=%b, required lvl=8 ov=0", req_level, overflow);
    end
    drain("full_pop");
  endtask

  task automatic test_back_to_back();
    do_reset();
    slv_ready = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_req(IW'($urandom_range(0, 15)), $urandom, 1'b1);
      tick();
      checks++;
      if (slv_valid !== 1'b1 || req_level !== 4'd1) begin
        errors++; $display("FAIL b2b_%0d: got v=%b lvl=%0d, required v=1 lvl=1", i, slv_valid, req_level);
      end
    end
    drain("b2b");
  endtask

  task automatic test_interleave();
    do_reset();
    slv_ready = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(ids[i], 32'h100 + i, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      send_rsp(32'h10 + i);
      tick();
    end
    slv_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h10 || rsp_id !== 4'd1) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b d=%h id=%h, required v=1 d=00000010 id=1", c, rsp_valid, rsp_data, rsp_id);
      end
      tick();
    end
    drain("interleave");
  endtask

  task automatic test_orphan();
    do_reset();
    rsp_ready = 1'b1;
    send_rsp(32'h77);
    tick();
    slv_rsp_valid = 1'b0;
    checks++;
    if (orphan !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL orphan: got or=%b rv=%b, required or=1 rv=0", orphan, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_no_reply: got rv=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    slv_ready = 1'b1; rsp_ready = 1'b1;
    drive_req(4'd5, $urandom, 1'b1); tick();
    drive_req(4'd6, $urandom, 1'b1); tick();
    req_valid = 1'b0; tick();
    slv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(IW'(i), $urandom, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (req_level !== 4'd3) begin
      errors++; $display("FAIL mid_level: got lvl=%0d, required 3", req_level);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete(); exp_rsp_q.delete(); tag_q.delete();
    checks++;
    if (slv_valid !== 1'b0 || rsp_valid !== 1'b0 || req_level !== 4'd0) begin
      errors++; $display("FAIL mid_reset: got sv=%b rv=%b lvl=%0d, required 0 0 0", slv_valid, rsp_valid, req_level);
    end
    slv_ready = 1'b1;
    send_rsp(32'h99);
    tick();
    slv_rsp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rsp_valid !== 1'b0 || slv_valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale_%0d: got rv=%b sv=%b, required 0 0", c, rsp_valid, slv_valid);
      end
      tick();
    end
    checks++;
    if (orphan !== 1'b1) begin
      errors++; $display("FAIL mid_orphan: got %b, required 1", orphan);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full_pop();
    test_back_to_back();
    test_interleave();
    test_orphan();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || exp_rsp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got req=%0d rsp=%0d pending, required 0 0", exp_q.size(), exp_rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
